// File: rtl/mips_multicycle_control_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The master modport is the controller side.
interface mips_multicycle_control_if;
  logic [5:0] Op;
  logic       mem_ready;
  logic       mem_req;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  Op, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op, state
  );

  modport slave (
    output Op, mem_ready,
    input  mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM (lw, sw, R-type, beq, addi, j) with optional
// memory handshake; outputs are state-decoded apart from the mem_ready-gated writes.
module mips_multicycle_control #(
  parameter int unsigned WAIT_MEM = 1
) (
  input logic                          Clk,
  input logic                          reset,
  mips_multicycle_control_if.master    bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   mr;

  assign mr = (WAIT_MEM != 0) ? bus.mem_ready : 1'b1;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = FETCH;
    bus.state      = state_q;
    bus.mem_req    = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.Branch     = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = '0;
    bus.ALUOp      = '0;
    bus.PCSrc      = '0;
    bus.illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        bus.mem_req = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = mr;
        bus.PCWrite = mr;
        state_d     = mr ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.Op)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = EXECUTE;
          6'b000100:            state_d = BRANCH;
          6'b001000:            state_d = ADDIEX;
          6'b000010:            state_d = JUMP;
          default: begin
            bus.illegal_op = 1'b1;
            state_d        = FETCH;
          end
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = (bus.Op == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.mem_req = 1'b1;
        bus.IorD    = 1'b1;
        state_d     = mr ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      MEMWR: begin
        bus.mem_req  = 1'b1;
        bus.IorD     = 1'b1;
        bus.MemWrite = mr;
        state_d      = mr ? FETCH : MEMWR;
      end
      EXECUTE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        state_d     = ALUWB;
      end
      ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b01;
        bus.PCSrc   = 2'b01;
        bus.Branch  = 1'b1;
      end
      ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB: begin
        bus.RegWrite = 1'b1;
      end
      JUMP: begin
        bus.PCSrc   = 2'b10;
        bus.PCWrite = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    // state is already FETCH during reset; only the mem_ready-gated enables need masking
    if (reset) begin
      bus.IRWrite    = 1'b0;
      bus.PCWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed vector table, reset/abort sequences,
// WAIT_MEM=0 sequences and a randomized run against an instruction-path model.
module tb_mips_multicycle_control;

  logic Clk = 1'b0;
  logic reset;

  mips_multicycle_control_if bus ();
  mips_multicycle_control_if bus_nw ();

  mips_multicycle_control #(.WAIT_MEM(1)) u_dut (.Clk(Clk), .reset(reset), .bus(bus));
  mips_multicycle_control #(.WAIT_MEM(0)) u_dut_nw (.Clk(Clk), .reset(reset), .bus(bus_nw));

  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // {mem_req,IorD,MemWrite,IRWrite,PCWrite,Branch,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,PCSrc,illegal_op}
  localparam logic [16:0] F1   = 17'b1_0_0_1_1_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] F0   = 17'b1_0_0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] DECI = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] MA   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] MRD  = 17'b1_1_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] MWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] MWR0 = 17'b1_1_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] MWR1 = 17'b1_1_1_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] EX   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] AWB  = 17'b0_0_0_0_0_0_1_1_0_0_00_00_00_0;
  localparam logic [16:0] BR   = 17'b0_0_0_0_0_1_0_0_0_1_00_01_01_0;
  localparam logic [16:0] AIWB = 17'b0_0_0_0_0_0_1_0_0_0_00_00_00_0;
  localparam logic [16:0] JMP  = 17'b0_0_0_0_1_0_0_0_0_0_00_00_10_0;

  logic [16:0] cw, cw_nw;
  assign cw = {bus.mem_req, bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.Branch,
               bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB,
               bus.ALUOp, bus.PCSrc, bus.illegal_op};
  assign cw_nw = {bus_nw.mem_req, bus_nw.IorD, bus_nw.MemWrite, bus_nw.IRWrite, bus_nw.PCWrite,
                  bus_nw.Branch, bus_nw.RegWrite, bus_nw.RegDst, bus_nw.MemtoReg, bus_nw.ALUSrcA,
                  bus_nw.ALUSrcB, bus_nw.ALUOp, bus_nw.PCSrc, bus_nw.illegal_op};

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] ctrl;
  } vec_t;

  vec_t vecs [30];

  task automatic chk(input string name, input logic [3:0] st, input logic [16:0] c,
                     input logic [3:0] est, input logic [16:0] ec);
    checks++;
    if ({st, c} !== {est, ec}) begin
      errors++;
      $display("FAIL %s @%0t: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
               name, $time, st, c, est, ec);
    end
  endtask

  task automatic set_in(input logic [5:0] op, input logic mr);
    bus.Op = op;
    bus.mem_ready = mr;
    bus_nw.Op = op;
    bus_nw.mem_ready = mr;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'd35 || op == 6'd43 || op == 6'd0 || op == 6'd4 || op == 6'd8 || op == 6'd2;
  endfunction

  // Expected outputs for a state, with the mem_ready-gated writes folded in
  function automatic logic [16:0] model_ctrl(input int st, input bit mr, input bit ill);
    case (st)
      0:       return mr ? F1 : F0;
      1:       return ill ? DECI : DEC;
      2, 9:    return MA;
      3:       return MRD;
      4:       return MWB;
      5:       return mr ? MWR1 : MWR0;
      6:       return EX;
      7:       return AWB;
      8:       return BR;
      10:      return AIWB;
      11:      return JMP;
      default: return '0;
    endcase
  endfunction

  logic [5:0] cur_op;
  int         path[$];
  int         exp_st;
  bit         do_rst, rmr;

  task automatic route(input logic [5:0] op);
    case (op)
      6'd35:   path = '{1, 2, 3, 4};
      6'd43:   path = '{1, 2, 5};
      6'd0:    path = '{1, 6, 7};
      6'd4:    path = '{1, 8};
      6'd8:    path = '{1, 9, 10};
      6'd2:    path = '{1, 11};
      default: path = '{1};
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [6];
    legal = '{6'd35, 6'd43, 6'd0, 6'd4, 6'd8, 6'd2};
    if ($urandom_range(0, 4) == 0) return 6'($urandom_range(0, 63));
    return legal[$urandom_range(0, 5)];
  endfunction

  initial begin
    vecs[0]  = '{6'd35, 1'b1, 4'd0,  F1};
    vecs[1]  = '{6'd35, 1'b1, 4'd1,  DEC};
    vecs[2]  = '{6'd35, 1'b1, 4'd2,  MA};
    vecs[3]  = '{6'd35, 1'b1, 4'd3,  MRD};
    vecs[4]  = '{6'd63, 1'b1, 4'd4,  MWB};
    vecs[5]  = '{6'd43, 1'b0, 4'd0,  F0};
    vecs[6]  = '{6'd43, 1'b1, 4'd0,  F1};
    vecs[7]  = '{6'd43, 1'b1, 4'd1,  DEC};
    vecs[8]  = '{6'd43, 1'b1, 4'd2,  MA};
    vecs[9]  = '{6'd35, 1'b0, 4'd5,  MWR0};
    vecs[10] = '{6'd43, 1'b0, 4'd5,  MWR0};
    vecs[11] = '{6'd43, 1'b0, 4'd5,  MWR0};
    vecs[12] = '{6'd43, 1'b1, 4'd5,  MWR1};
    vecs[13] = '{6'd0,  1'b1, 4'd0,  F1};
    vecs[14] = '{6'd0,  1'b1, 4'd1,  DEC};
    vecs[15] = '{6'd4,  1'b1, 4'd6,  EX};
    vecs[16] = '{6'd0,  1'b1, 4'd7,  AWB};
    vecs[17] = '{6'd4,  1'b1, 4'd0,  F1};
    vecs[18] = '{6'd4,  1'b1, 4'd1,  DEC};
    vecs[19] = '{6'd4,  1'b1, 4'd8,  BR};
    vecs[20] = '{6'd2,  1'b1, 4'd0,  F1};
    vecs[21] = '{6'd2,  1'b1, 4'd1,  DEC};
    vecs[22] = '{6'd2,  1'b1, 4'd11, JMP};
    vecs[23] = '{6'd8,  1'b1, 4'd0,  F1};
    vecs[24] = '{6'd8,  1'b1, 4'd1,  DEC};
    vecs[25] = '{6'd8,  1'b1, 4'd9,  MA};
    vecs[26] = '{6'd8,  1'b1, 4'd10, AIWB};
    vecs[27] = '{6'd63, 1'b1, 4'd0,  F1};
    vecs[28] = '{6'd63, 1'b1, 4'd1,  DECI};
    vecs[29] = '{6'd63, 1'b0, 4'd0,  F0};

    reset = 1'b0;
    set_in(6'd0, 1'b1);
    #10 reset = 1'b1;
    #1;
    chk("reset_async", bus.state, cw, 4'd0, F0);
    chk("reset_async_nw", bus_nw.state, cw_nw, 4'd0, F0);
    #9 reset = 1'b0;

    for (int i = 0; i < 30; i++) begin
      set_in(vecs[i].op, vecs[i].mr);
      #1;
      chk($sformatf("vec%0d", i), bus.state, cw, vecs[i].st, vecs[i].ctrl);
      @(negedge Clk);
    end

    // reset while MEMRD waits: aborts the load before MEMWB
    do_reset();
    set_in(6'd35, 1'b1); #1 chk("lw_abort_f", bus.state, cw, 4'd0, F1);
    @(negedge Clk); #1 chk("lw_abort_d", bus.state, cw, 4'd1, DEC);
    @(negedge Clk); #1 chk("lw_abort_a", bus.state, cw, 4'd2, MA);
    @(negedge Clk); set_in(6'd35, 1'b0); #1 chk("lw_abort_r0", bus.state, cw, 4'd3, MRD);
    @(negedge Clk); #1 chk("lw_abort_r1", bus.state, cw, 4'd3, MRD);
    #4 reset = 1'b1; set_in(6'd35, 1'b1);
    #1 chk("lw_abort_rst", bus.state, cw, 4'd0, F0);
    @(posedge Clk); #1 chk("lw_abort_hold", bus.state, cw, 4'd0, F0);
    @(negedge Clk); reset = 1'b0; #1 chk("lw_abort_rel", bus.state, cw, 4'd0, F1);

    // reset while MEMWR waits: no MemWrite for the aborted store
    do_reset();
    set_in(6'd43, 1'b1);
    @(negedge Clk); @(negedge Clk);
    @(negedge Clk); set_in(6'd43, 1'b0); #1 chk("sw_abort_w", bus.state, cw, 4'd5, MWR0);
    #4 reset = 1'b1; set_in(6'd43, 1'b1);
    #1 chk("sw_abort_rst", bus.state, cw, 4'd0, F0);
    @(negedge Clk); reset = 1'b0; #1 chk("sw_abort_rel", bus.state, cw, 4'd0, F1);

    // WAIT_MEM=0 instance advances with mem_ready held low; main instance stalls in FETCH
    begin
      logic [3:0]  st_lw [6];
      logic [16:0] cw_lw [6];
      logic [3:0]  st_sw [4];
      logic [16:0] cw_sw [4];
      st_lw = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      cw_lw = '{F1, DEC, MA, MRD, MWB, F1};
      st_sw = '{4'd1, 4'd2, 4'd5, 4'd0};
      cw_sw = '{DEC, MA, MWR1, F1};
      do_reset();
      set_in(6'd35, 1'b0);
      for (int k = 0; k < 6; k++) begin
        if (k > 0) @(negedge Clk);
        #1 chk($sformatf("nw_lw%0d", k), bus_nw.state, cw_nw, st_lw[k], cw_lw[k]);
        chk($sformatf("stall_main%0d", k), bus.state, cw, 4'd0, F0);
      end
      set_in(6'd43, 1'b0);
      for (int k = 0; k < 4; k++) begin
        @(negedge Clk);
        #1 chk($sformatf("nw_sw%0d", k), bus_nw.state, cw_nw, st_sw[k], cw_sw[k]);
      end
    end

    // randomized run against the instruction-path model
    do_reset();
    exp_st = 0;
    path.delete();
    cur_op = '0;
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) @(negedge Clk);
      do_rst = ($urandom_range(0, 63) == 0);
      rmr    = ($urandom_range(0, 3) != 0);
      reset  = do_rst;
      if (exp_st == 1 || exp_st == 2) set_in(cur_op, rmr);
      else                            set_in(6'($urandom_range(0, 63)), rmr);
      #1;
      if (do_rst)
        chk("rand_rst", bus.state, cw, 4'd0, F0);
      else
        chk("rand", bus.state, cw, 4'(exp_st),
            model_ctrl(exp_st, rmr, (exp_st == 1) && !is_legal(cur_op)));
      if (do_rst) begin
        exp_st = 0;
        path.delete();
      end else if ((exp_st == 0 || exp_st == 3 || exp_st == 5) && !rmr) begin
        exp_st = exp_st;
      end else if (exp_st == 0) begin
        cur_op = pick_op();
        route(cur_op);
        exp_st = path.pop_front();
      end else if (path.size() == 0) begin
        exp_st = 0;
      end else begin
        exp_st = path.pop_front();
      end
    end
    @(negedge Clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
